// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_ctrl_pkg
// Brief    : Shared state encoding, reset baud divisor and small helpers for
//            the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    // Baud divisor programmed into the UART straight after reset.
    localparam logic [15:0] c_BAUD_INIT_DEFAULT = 16'd434;

    // Controller states; width fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        INIT_BAUD = 3'd0,
        IDLE      = 3'd1,
        CFG_WR    = 3'd2,
        DATA_WR   = 3'd3,
        SETTLE    = 3'd4,
        WAIT_TX   = 3'd5
    } state_t;

    // Next index after idx, wrapping at n.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request bit at or
//            above ptr, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    // Walk from the farthest offset back to ptr so the nearest set bit wins.
    always_comb begin : p_search
        int w_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = int'(ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter among NUM_REQ byte sources with
//            round-robin fairness, and serialises baud reprogramming requests
//            onto the same register write port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter logic [15:0] BAUD_INIT  = c_BAUD_INIT_DEFAULT,
    parameter int          SETTLE_CYC = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cfg_baud_valid,
    input  logic [15:0]                cfg_baud,
    output logic                       cfg_baud_ready,
    output logic                       uart_data_sel,
    output logic                       uart_baud_sel,
    output logic                       uart_wr,
    output logic [15:0]                uart_wdata,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST =
        (SETTLE_CYC > 0) ? c_CNT_W'(SETTLE_CYC - 1) : '0;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [7:0]           r_byte;
    logic [15:0]          r_baud_word;
    logic [c_CNT_W-1:0]   r_settle_cnt;
    logic                 r_wr;
    logic                 r_data_sel;
    logic                 r_baud_sel;

    logic                 w_grant_valid;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic [7:0]           w_sel_byte;
    logic                 w_idle;
    logic                 w_take_cfg;
    logic                 w_take_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Baud reprogramming always beats pending bytes in IDLE.
    assign w_idle     = (r_state == IDLE);
    assign w_take_cfg = w_idle && cfg_baud_valid;
    assign w_take_req = w_idle && !cfg_baud_valid && w_grant_valid;

    // Pick the winning requester's byte out of the flattened data bus.
    always_comb begin
        w_sel_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == c_IDX_W'(i)) begin
                w_sel_byte = req_data[i*8 +: 8];
            end
        end
    end

    // Accept pulses coincide with the IDLE cycle that makes the decision.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_take_req && (w_grant_idx == c_IDX_W'(i));
        end
    end

    assign cfg_baud_ready = w_take_cfg;

    // Controller FSM; write strobes are registered one-cycle pulses that
    // default low and are raised only on entry into a write state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= INIT_BAUD;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_byte       <= 8'h00;
            r_baud_word  <= 16'h0000;
            r_settle_cnt <= '0;
            r_wr         <= 1'b0;
            r_data_sel   <= 1'b0;
            r_baud_sel   <= 1'b0;
        end else begin
            r_wr       <= 1'b0;
            r_data_sel <= 1'b0;
            r_baud_sel <= 1'b0;
            case (r_state)
                INIT_BAUD: begin
                    // First cycle out of reset raises the strobe, the second
                    // (strobe already high) moves on.
                    if (!r_wr) begin
                        r_wr        <= 1'b1;
                        r_baud_sel  <= 1'b1;
                        r_baud_word <= BAUD_INIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_take_cfg) begin
                        r_state     <= CFG_WR;
                        r_wr        <= 1'b1;
                        r_baud_sel  <= 1'b1;
                        r_baud_word <= cfg_baud;
                    end else if (w_take_req) begin
                        r_state    <= DATA_WR;
                        r_wr       <= 1'b1;
                        r_data_sel <= 1'b1;
                        r_byte     <= w_sel_byte;
                        r_grant_id <= w_grant_idx;
                    end
                end
                CFG_WR: begin
                    r_state <= IDLE;
                end
                DATA_WR: begin
                    r_settle_cnt <= '0;
                    r_state      <= (SETTLE_CYC == 0) ? WAIT_TX : SETTLE;
                end
                SETTLE: begin
                    // The UART may not have raised busy yet, so ignore it here.
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= WAIT_TX;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (!uart_tx_busy) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= c_IDX_W'(wrap_next(int'(r_grant_id), NUM_REQ));
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign uart_wr       = r_wr;
    assign uart_data_sel = r_data_sel;
    assign uart_baud_sel = r_baud_sel;
    assign uart_wdata    = ({16{r_data_sel}} & {8'h00, r_byte})
                         | ({16{r_baud_sel}} & r_baud_word);
    assign grant_id      = r_grant_id;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire
